fib_controller: RTL and testbench

FIB_CONTROLLER -- requirements
Module: fib_controller

---
 rtl/fib_pkg.sv | 30 +++
 rtl/fib_controller.sv | 120 ++++++++++++
 tb/tb_fib_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fib_pkg
//  Description : Shared types and constants for the Fibonacci controller:
//                state enumeration, operand/data widths and the largest
//                n whose F(n) fits the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

   localparam int N_W       = 5;
   localparam int DATA_W    = 16;
   localparam int FIB_MAX_N = 24;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_INIT  = 3'd2,
      S_RUN   = 3'd3,
      S_STORE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // True when n can be computed without overflowing DATA_W (F(24)=46368).
   function automatic logic n_in_range(input logic [N_W-1:0] n);
      return (n != '0) && (n <= N_W'(FIB_MAX_N));
   endfunction

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fib_controller
//  Description : Control FSM for an iterative Fibonacci datapath. Sequences
//                load, seed, iterate and store of F(n), with range checking,
//                abort and a done/ack handshake towards the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_controller
   import fib_pkg::*;
(
   input  logic           clk,
   input  logic           usr_reset_n,
   input  logic           start,
   input  logic           ack,
   input  logic           abort,
   input  logic [N_W-1:0] count_to,
   input  logic [N_W-1:0] count,
   output logic           cu_reset,
   output logic           first_time,
   output logic           inout_enb,
   output logic           enb,
   output logic           busy,
   output logic           done,
   output logic           err
);

   state_t state;
   logic   last_iter;
   logic   busy_state;
   logic   aborting;

   // 5-bit compare: the counter has reached n-1 advances, so current holds F(n).
   assign last_iter  = (count == (count_to - N_W'(1)));
   assign busy_state = (state == S_LOAD) || (state == S_INIT) ||
                       (state == S_RUN)  || (state == S_STORE);
   assign aborting   = busy_state && abort;

   // State register with registered done/err flags; done lags DONE entry by one cycle.
   always_ff @(posedge clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         state <= S_IDLE;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD;
                  err   <= 1'b0;
               end
            end
            S_LOAD: begin
               state <= abort ? S_IDLE : S_INIT;
            end
            S_INIT: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (!n_in_range(count_to)) begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (last_iter) begin
                  state <= S_STORE;
               end
            end
            S_STORE: begin
               state <= abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
               // ack has priority; abort is not looked at here.
               if (ack) begin
                  state <= S_IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Datapath strobes decoded from state; RUN enb also depends on the counter,
   // and an abort turns the cycle into a counter clear with nothing else active.
   always_comb begin
      cu_reset   = 1'b0;
      first_time = 1'b0;
      inout_enb  = 1'b0;
      enb        = 1'b0;
      busy       = busy_state;
      case (state)
         S_LOAD:  inout_enb = 1'b1;
         S_INIT: begin
            cu_reset   = 1'b1;
            first_time = 1'b1;
            enb        = 1'b1;
         end
         S_RUN:   enb       = !last_iter;
         S_STORE: inout_enb = 1'b1;
         default: ;
      endcase
      if (aborting) begin
         cu_reset   = 1'b1;
         first_time = 1'b0;
         inout_enb  = 1'b0;
         enb        = 1'b0;
      end
   end

endmodule : fib_controller
`default_nettype wire

// File: tb/tb_fib_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_controller
//  Description : Self-checking bench for fib_controller with a behavioural
//                datapath and a scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_controller;
   import fib_pkg::*;

   logic              clk         = 1'b0;
   logic              usr_reset_n = 1'b0;
   logic              start       = 1'b0;
   logic              ack         = 1'b0;
   logic              abort       = 1'b0;
   logic [N_W-1:0]    number_in   = '0;
   logic [N_W-1:0]    count_to;
   logic [N_W-1:0]    count;
   logic              cu_reset, first_time, inout_enb, enb, busy, done, err;
   logic [DATA_W-1:0] cur, prev, nth_fib;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int   n;
      int   fib;
      logic err;
      int   lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   fib_controller dut (
      .clk         (clk),
      .usr_reset_n (usr_reset_n),
      .start       (start),
      .ack         (ack),
      .abort       (abort),
      .count_to    (count_to),
      .count       (count),
      .cu_reset    (cu_reset),
      .first_time  (first_time),
      .inout_enb   (inout_enb),
      .enb         (enb),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // Behavioural datapath: input/output registers, counter, current/prev pair.
   always @(posedge clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         count_to <= '0;
         count    <= '0;
         cur      <= '0;
         prev     <= '0;
         nth_fib  <= '0;
      end else begin
         if (inout_enb) begin
            count_to <= number_in;
            nth_fib  <= cur;
         end
         if (cu_reset)   count <= '0;
         else if (enb)   count <= count + 1'b1;
         if (enb) begin
            if (first_time) begin
               cur  <= 1;
               prev <= 0;
            end else begin
               cur  <= cur + prev;
               prev <= cur;
            end
         end
      end
   end

   function automatic int fib_ref(input int n);
      int a = 0;
      int b = 1;
      int t;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start a run of n; glitch_cyc >= 0 re-pulses start at that cycle while busy.
   task automatic run_to_done(input int n, input int glitch_cyc);
      exp_t e;
      exp_t got;
      int   cyc;
      int   enb_run;
      int   io;
      e.n   = n;
      e.err = (n == 0) || (n > FIB_MAX_N);
      e.fib = e.err ? 0 : fib_ref(n);
      e.lat = e.err ? 3 : n + 4;
      sb.push_back(e);
      @(negedge clk);
      number_in = N_W'(n);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared_on_start", {31'd0, err}, 32'd0);
      check("busy_in_load", {31'd0, busy}, 32'd1);
      cyc = 0; enb_run = 0; io = 0;
      while (!done && cyc < 100) begin
         if (enb && !first_time) enb_run++;
         if (inout_enb) io++;
         start = (cyc == glitch_cyc);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      got = sb.pop_front();
      check("done_latency", cyc, got.lat);
      check("err_flag", {31'd0, err}, {31'd0, got.err});
      check("inout_enb_pulses", io, got.err ? 2'd1 : 2'd2);
      if (!got.err) begin
         check("nth_fib", {16'd0, nth_fib}, got.fib);
         check("run_enb_cycles", enb_run, got.n - 1);
      end
   endtask

   // Hold DONE for two cycles, optionally pulse start in DONE, then ack.
   task automatic finish_ack(input logic with_abort, input logic start_in_done);
      for (int i = 0; i < 2; i++) begin
         check("done_held", {31'd0, done}, 32'd1);
         check("not_busy_in_done", {31'd0, busy}, 32'd0);
         start = (i == 1) ? start_in_done : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      ack   = 1'b1;
      abort = with_abort;
      @(negedge clk);
      ack   = 1'b0;
      abort = 1'b0;
      check("done_after_ack", {31'd0, done}, 32'd0);
      check("idle_after_ack", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("start_not_queued", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs", {25'd0, cu_reset, first_time, inout_enb, enb, busy, done, err}, 32'd0);
      usr_reset_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {30'd0, busy, done}, 32'd0);

      run_to_done(1, -1);
      finish_ack(1'b0, 1'b0);

      run_to_done(10, 3);
      finish_ack(1'b0, 1'b1);

      run_to_done(24, -1);
      finish_ack(1'b1, 1'b0);

      run_to_done(0, -1);
      finish_ack(1'b0, 1'b0);
      run_to_done(25, -1);
      // Reset while in DONE with err set
      usr_reset_n = 1'b0;
      #1;
      check("reset_clears_err_done", {30'd0, err, done}, 32'd0);
      @(negedge clk);
      usr_reset_n = 1'b1;
      @(negedge clk);

      // Abort in IDLE is ignored
      abort = 1'b1;
      #1;
      check("abort_idle_cu_reset", {31'd0, cu_reset}, 32'd0);
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      // Abort at the 5th RUN cycle of n=20
      number_in = 5'd20;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("run_enb_before_abort", {31'd0, enb}, 32'd1);
      abort = 1'b1;
      #1;
      check("abort_strobes", {28'd0, cu_reset, first_time, inout_enb, enb}, 32'b1000);
      @(negedge clk);
      abort = 1'b0;
      check("abort_to_idle", {29'd0, busy, done, cu_reset}, 32'd0);
      check("abort_count_clear", {27'd0, count}, 32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      run_to_done(5, -1);
      finish_ack(1'b0, 1'b0);

      // Reset mid-RUN of n=15
      number_in = 5'd15;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_mid_run", {31'd0, busy}, 32'd1);
      usr_reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {25'd0, cu_reset, first_time, inout_enb, enb, busy, done, err}, 32'd0);
      @(negedge clk);
      usr_reset_n = 1'b1;
      repeat (25) @(negedge clk);
      check("reset_no_done", {30'd0, busy, done}, 32'd0);

      // Random legal n against the reference model
      for (int r = 0; r < 4; r++) begin
         run_to_done(int'($urandom_range(1, FIB_MAX_N)), -1);
         finish_ack(1'b0, 1'b0);
      end

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_fib_controller
`default_nettype wire
